// File: rtl/sub_pkg.sv
// Shared definitions for the operand loader that feeds full_substractor_n_bits.
//   SUB_WIDTH_DEFAULT : default operand/result width in bits
//   state_t           : loader sequencing states
package sub_pkg;

  localparam int SUB_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_B = 2'd1,
    CALC   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/full_substractor_n_bits.sv
// N-bit combinational subtractor that sits alongside sub_operand_loader.
// Ports:
//   a, b : operands (minuend, subtrahend)
//   y    : a - b, modulo 2^N
module full_substractor_n_bits
  import sub_pkg::*;
#(
  parameter int N = SUB_WIDTH_DEFAULT
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  assign y = a - b;

endmodule

// File: rtl/sub_operand_loader.sv
// Collects two operand words over a valid/ready input stream (first word A,
// second word B), presents them to an external full_substractor_n_bits,
// captures its difference and offers it on a valid/ready output.
// Optional feature macro: SUB_LOADER_BORROW_EN -- adds a registered borrow
// output and clamps the result to zero when A < B.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_data/in_valid     : operand stream (A then B)
//   in_ready             : loader can take an operand (depends on state only)
//   sub_a, sub_b         : registered operands to the subtractor
//   sub_y                : difference returned by the subtractor
//   out_data/out_valid   : registered result, held until consumed
//   out_ready            : downstream takes out_data
//   borrow               : (SUB_LOADER_BORROW_EN only) A < B for held result
module sub_operand_loader
  import sub_pkg::*;
#(
  parameter int N = SUB_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] sub_a,
  output logic [N-1:0] sub_b,
  input  logic [N-1:0] sub_y,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
`ifdef SUB_LOADER_BORROW_EN
  ,
  output logic         borrow
`endif
);

  state_t state, state_nxt;
  logic   ld_a, ld_b, ld_res, out_fire;

`ifdef SUB_LOADER_BORROW_EN
  logic   borrow_calc;

  // Saturate at zero instead of wrapping when the subtraction borrows.
  function automatic logic [N-1:0] sat_result(input logic [N-1:0] y,
                                              input logic         brw);
    return brw ? '0 : y;
  endfunction

  assign borrow_calc = (sub_a < sub_b);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; in_ready depends only on state, the
  // load strobes are internal and never reach an output combinationally.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_res    = 1'b0;
    out_fire  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_a      = 1'b1;
          state_nxt = WAIT_B;
        end
      end
      WAIT_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_b      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        ld_res    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) begin
          out_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers: sub_a/sub_b keep their value until overwritten by the
  // next accepted word, so they stay valid through CALC and DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_a <= '0;
      sub_b <= '0;
    end else begin
      if (ld_a) sub_a <= in_data;
      if (ld_b) sub_b <= in_data;
    end
  end

  // Result registers: captured once in CALC, held until the output transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
`ifdef SUB_LOADER_BORROW_EN
      borrow    <= 1'b0;
`endif
    end else begin
      if (ld_res) begin
`ifdef SUB_LOADER_BORROW_EN
        out_data <= sat_result(sub_y, borrow_calc);
        borrow   <= borrow_calc;
`else
        out_data <= sub_y;
`endif
        out_valid <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
